sam_rv32i_trace_buf: RTL and testbench

Receive-side trace capture for the sam_rv32i core. Samples the core's NPC / WB_OUT outputs and records one (NPC, WB_OUT) entry each time NPC changes. Entries go into an internal FIFO, and a host or debug bridge drains them over a valid/ready read port. The block sits beside the core at SoC/bench top level and is the consumer of the core's program-counter and writeback stream.

---
 rtl/sam_rv32i_trace_buf.sv | 152 +++++++++++++++
 tb/tb_sam_rv32i_trace_buf.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sam_rv32i_trace_buf.sv
// sam_rv32i_trace_buf: records an (NPC, WB_OUT) entry each time the core's NPC
// changes. Entries are held in a FIFO and drained through a show-ahead
// valid/ready read port. Sticky overflow flag plus a saturating drop counter.
// Optional feature macro: TRACE_TIMESTAMP_EN adds a 16-bit cycle timestamp per
// entry, presented on trc_ts.
module sam_rv32i_trace_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          RN,
  input  logic          cap_en,
  input  logic [31:0]   npc_in,
  input  logic [31:0]   wb_in,
  input  logic          trc_ready,
  input  logic          clr_ovf,
  output logic          trc_valid,
  output logic [31:0]   trc_npc,
  output logic [31:0]   trc_wb,
  output logic [AW:0]   count,
  output logic          overflow,
`ifdef TRACE_TIMESTAMP_EN
  output logic [15:0]   trc_ts,
`endif
  output logic [15:0]   drop_cnt
);

`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = 80;
`else
  localparam int EW = 64;
`endif

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          primed_q, primed_d;
  logic [31:0]   last_npc_q, last_npc_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;
  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] entry_in;

  logic cap, pop, full, push, drop;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;

  // Free-running cycle counter sampled into each captured entry.
  always_ff @(posedge clk) begin
    if (RN) ts_q <= 16'd0;
    else    ts_q <= ts_q + 16'd1;
  end

  assign entry_in = {ts_q, npc_in, wb_in};
  assign trc_ts   = head_q[79:64];
`else
  assign entry_in = {npc_in, wb_in};
`endif

  // Capture decision, push/pop qualification and all next-state values.
  always_comb begin
    cap  = cap_en && (!primed_q || (npc_in != last_npc_q));
    pop  = (count_q != '0) && trc_ready;
    full = (count_q == DEPTH_C);
    push = cap && (!full || pop);
    drop = cap && full && !pop;

    primed_d   = primed_q;
    last_npc_d = last_npc_q;
    if (cap_en) begin
      primed_d   = 1'b1;
      last_npc_d = npc_in;
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Head register tracks the entry at rd_ptr; bypass the incoming entry
    // when it becomes the head in the same cycle it is written.
    head_d = head_q;
    if (push && (count_q == '0)) begin
      head_d = entry_in;
    end else if (pop) begin
      if (count_q == {{AW{1'b0}}, 1'b1}) begin
        if (push) head_d = entry_in;
      end else begin
        head_d = mem[rd_ptr_q + PTR_ONE];
      end
    end

    // A drop in the same cycle as a clear still registers as one drop.
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      if (clr_ovf)                drop_d = 16'd1;
      else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end else if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 16'd0;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= entry_in;
  end

  // Control state and head register.
  always_ff @(posedge clk) begin
    if (RN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      primed_q   <= 1'b0;
      last_npc_q <= 32'd0;
      ovf_q      <= 1'b0;
      drop_q     <= 16'd0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      primed_q   <= primed_d;
      last_npc_q <= last_npc_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
    end
  end

  assign trc_valid = (count_q != '0);
  assign trc_npc   = head_q[63:32];
  assign trc_wb    = head_q[31:0];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sam_rv32i_trace_buf.sv
// Scoreboard bench for sam_rv32i_trace_buf: a queue-based reference model of
// capture/dedup, FIFO ordering, overflow and drop counting.
module tb_sam_rv32i_trace_buf;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        RN = 1'b1;
  logic        cap_en = 1'b0;
  logic [31:0] npc_in = '0;
  logic [31:0] wb_in = '0;
  logic        trc_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        trc_valid;
  logic [31:0] trc_npc;
  logic [31:0] trc_wb;
  logic [AW:0] count;
  logic        overflow;
  logic [15:0] drop_cnt;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] trc_ts;
`endif

  sam_rv32i_trace_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .RN        (RN),
    .cap_en    (cap_en),
    .npc_in    (npc_in),
    .wb_in     (wb_in),
    .trc_ready (trc_ready),
    .clr_ovf   (clr_ovf),
    .trc_valid (trc_valid),
    .trc_npc   (trc_npc),
    .trc_wb    (trc_wb),
    .count     (count),
    .overflow  (overflow),
`ifdef TRACE_TIMESTAMP_EN
    .trc_ts    (trc_ts),
`endif
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [63:0] sb[$];
  logic        m_primed = 1'b0;
  logic [31:0] m_last = '0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_drop = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check_val("count", {59'd0, count}, 64'(sb.size()));
    check_val("valid", {63'd0, trc_valid}, {63'd0, (sb.size() != 0)});
    check_val("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    check_val("drop_cnt", {48'd0, drop_cnt}, {48'd0, m_drop});
  endtask

  // One clock cycle of stimulus; model predicts pop data and post-edge state.
  task automatic step(input logic ce, input logic [31:0] npc, input logic [31:0] wb,
                      input logic rdy, input logic clr);
    logic cap, pop, dropped;
    logic [63:0] head;
    @(negedge clk);
    RN = 1'b0; cap_en = ce; npc_in = npc; wb_in = wb; trc_ready = rdy; clr_ovf = clr;
    cap = ce && (!m_primed || (npc != m_last));
    if (ce) begin
      m_last = npc;
      m_primed = 1'b1;
    end
    pop = rdy && (sb.size() != 0);
    dropped = 1'b0;
    if (pop) begin
      head = sb.pop_front();
      check_val("head", {trc_npc, trc_wb}, head);
      $display("POP npc=%08h wb=%08h", trc_npc, trc_wb);
    end
    if (cap) begin
      if (sb.size() < DEPTH) begin
        sb.push_back({npc, wb});
      end else begin
        dropped = 1'b1;
        m_ovf = 1'b1;
        if (clr) m_drop = 16'd1;
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    if (clr && !dropped) begin
      m_ovf = 1'b0;
      m_drop = 16'd0;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      RN = 1'b1; cap_en = 1'b1; npc_in = $urandom; wb_in = $urandom;
      trc_ready = 1'($urandom_range(0, 1)); clr_ovf = 1'b0;
      @(posedge clk);
      #1;
    end
    sb.delete();
    m_primed = 1'b0; m_last = '0; m_ovf = 1'b0; m_drop = '0;
    check_state();
    check_val("rst_npc", {32'd0, trc_npc}, 64'd0);
    check_val("rst_wb", {32'd0, trc_wb}, 64'd0);
    $display("RESET done");
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      if (sb.size() == 0) break;
      step(1'b0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0);
    end
    check_val("drained", {59'd0, count}, 64'd0);
  endtask

  initial begin
    // 1: reset
    do_reset(2);

    // 2: capture and dedup
    step(1'b1, 32'h0, 32'h11, 1'b1, 1'b0);
    step(1'b1, 32'h0, 32'h22, 1'b1, 1'b0);
    step(1'b1, 32'h4, 32'h33, 1'b1, 1'b0);
    step(1'b1, 32'h4, 32'h44, 1'b1, 1'b0);
    step(1'b1, 32'h8, 32'h55, 1'b1, 1'b0);
    drain();

    // 3: cap_en gating (last_npc holds while disabled)
    step(1'b0, 32'h10, 32'h1, 1'b0, 1'b0);
    step(1'b0, 32'h14, 32'h2, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'h3, 1'b0, 1'b0);
    step(1'b1, 32'h14, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h18, 32'h5, 1'b0, 1'b0);
    drain();

    // 4: overflow, drop+clear same cycle, drain order, clear
    for (int i = 0; i < 18; i++) step(1'b1, 32'(i * 4), 32'(32'hA000 + i), 1'b0, 1'b0);
    step(1'b1, 32'h48, 32'hA012, 1'b0, 1'b1);
    drain();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // 5: full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(32'h200 + i * 4), 32'(32'hB000 + i), 1'b0, 1'b0);
    step(1'b1, 32'h100, 32'hC100, 1'b1, 1'b0);
    drain();

    // 6: reset mid-stream, then first capture after reset
    for (int i = 0; i < 5; i++) step(1'b1, 32'(32'h300 + i * 4), 32'(32'hD000 + i), 1'b0, 1'b0);
    do_reset(1);
    step(1'b1, 32'h0, 32'hE000, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'hE001, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
